// File: rtl/fir_mac_scheduler_if.sv
// ---------------------------------------------------------------------------
// fir_mac_scheduler_if
//   Groups the streaming and tap-configuration handshakes of the FIR
//   scheduler into one bundle.
//   x_*   : input sample stream (ready/valid)
//   y_*   : output sample stream (ready/valid, y_last marks end of run)
//   cfg_* : AXI-lite side tap RAM access request; cfg_gnt says it was
//           performed this cycle (read data appears on tap_Do next cycle)
//   modport slave  : the scheduler's view
//   modport master : the environment's view (stream source/sink, cfg host)
// ---------------------------------------------------------------------------
interface fir_mac_scheduler_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   x_valid;
    logic                   x_ready;
    logic [pDATA_WIDTH-1:0] x_data;

    logic                   y_valid;
    logic                   y_ready;
    logic [pDATA_WIDTH-1:0] y_data;
    logic                   y_last;

    logic                   cfg_req;
    logic                   cfg_we;
    logic [pADDR_WIDTH-1:0] cfg_addr;
    logic [pDATA_WIDTH-1:0] cfg_wdata;
    logic                   cfg_gnt;

    modport slave (
        input  x_valid, x_data, y_ready, cfg_req, cfg_we, cfg_addr, cfg_wdata,
        output x_ready, y_valid, y_data, y_last, cfg_gnt
    );

    modport master (
        output x_valid, x_data, y_ready, cfg_req, cfg_we, cfg_addr, cfg_wdata,
        input  x_ready, y_valid, y_data, y_last, cfg_gnt
    );
endinterface

// File: rtl/fir_mac_scheduler.sv
// ---------------------------------------------------------------------------
// fir_mac_scheduler
//   Sequencer for the FIR datapath. Keeps the x history as a circular buffer
//   in data RAM, runs NTAP multiply-accumulate steps per accepted sample and
//   emits one y per x. Shares tap RAM with AXI-lite tap accesses; compute has
//   absolute priority.
// Ports
//   axis_clk, axis_rst_n        : clock, async active-low reset
//   ap_start, data_length       : start pulse, sample count (sampled on start)
//   ap_done_clr, ap_idle, ap_done : sticky done flag control/status
//   bus (slave)                 : x/y streams and cfg tap access
//   tap_*  / data_*             : single-port RAMs with 1-cycle read latency
// ---------------------------------------------------------------------------
module fir_mac_scheduler #(
    parameter int NTAP        = 11,
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    input  logic                   ap_done_clr,
    output logic                   ap_idle,
    output logic                   ap_done,
    fir_mac_scheduler_if.slave     bus,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);
    localparam int KW = $clog2(NTAP);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT_X, S_MAC, S_DRAIN, S_OUT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          wp_q;        // circular-buffer write pointer
    logic [KW-1:0]          k_q;         // tap index in MAC, word index in CLEAR
    logic [pDATA_WIDTH-1:0] acc_q;
    logic [31:0]            count_q;     // outputs handed off in this run
    logic [31:0]            len_q;
    logic                   mac_vld_q;   // RAM outputs hold a MAC operand pair
    logic                   done_q;

    logic          start_ok;
    logic          k_last;
    logic          last_sample;
    logic [KW-1:0] rd_idx;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [KW-1:0] w);
        return pADDR_WIDTH'({w, 2'b00});
    endfunction

    assign start_ok    = ap_start && (state_q == S_IDLE || state_q == S_DONE);
    assign k_last      = (k_q == KW'(NTAP - 1));
    assign last_sample = (count_q == len_q - 32'd1);
    // Read index (wp - k) mod NTAP; the wrap branch stays correct modulo 2^KW.
    assign rd_idx      = (wp_q >= k_q) ? (wp_q - k_q) : (wp_q + KW'(NTAP) - k_q);

    // ---------------- state register ----------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state_q <= S_IDLE;
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        else             state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (ap_start) state_d = S_CLEAR;
            S_CLEAR:  if (k_last) state_d = (len_q != 32'd0) ? S_WAIT_X : S_DONE;
            S_WAIT_X: if (bus.x_valid) state_d = S_MAC;
            S_MAC:    if (k_last) state_d = S_DRAIN;
            S_DRAIN:  state_d = S_OUT;
            S_OUT:    if (bus.y_ready) state_d = last_sample ? S_DONE : S_WAIT_X;
            S_DONE:   if (ap_start) state_d = S_CLEAR;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wp_q      <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            len_q     <= '0;
            mac_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mac_vld_q <= (state_q == S_MAC);

            if (start_ok) begin
                len_q   <= data_length;
                k_q     <= '0;
                wp_q    <= '0;
                count_q <= '0;
            end

            unique case (state_q)
                S_CLEAR, S_MAC: k_q <= k_last ? '0 : k_q + 1'b1;
                S_WAIT_X: if (bus.x_valid) begin
                    acc_q <= '0;
                    k_q   <= '0;
                end
                S_OUT: if (bus.y_ready) begin
                    wp_q    <= (wp_q == KW'(NTAP - 1)) ? '0 : wp_q + 1'b1;
                    count_q <= count_q + 32'd1;
                end
                default: ;
            endcase

            // Operands issued in the previous MAC cycle are on the RAM outputs now.
            if (mac_vld_q) acc_q <= acc_q + tap_Do * data_Do;

            // Set on DONE entry beats a same-cycle clear request.
            if (state_d == S_DONE && state_q != S_DONE) done_q <= 1'b1;
            else if (start_ok || ap_done_clr)           done_q <= 1'b0;
        end
    end

    // ---------------- status and streams ----------------
    assign ap_idle     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign ap_done     = done_q;
    assign bus.x_ready = (state_q == S_WAIT_X);
    assign bus.y_valid = (state_q == S_OUT);
    assign bus.y_last  = (state_q == S_OUT) && last_sample;
    assign bus.y_data  = acc_q;
    assign bus.cfg_gnt = bus.cfg_req &&
                         (state_q == S_IDLE || state_q == S_WAIT_X || state_q == S_DONE);

    // ---------------- RAM ports ----------------
    // NOTE: the RAMs themselves are never reset; CLEAR zeroes the x history
    // at the start of each run and taps keep whatever the host wrote.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (state_q == S_MAC) begin
            tap_EN = 1'b1;
            tap_A  = word_addr(k_q);
        end else if (bus.cfg_gnt) begin
            tap_EN = 1'b1;
            tap_WE = bus.cfg_we ? 4'hF : 4'h0;
            tap_A  = bus.cfg_addr;
            tap_Di = bus.cfg_wdata;
        end
    end

    always_comb begin
        data_EN = 1'b0;
        data_WE = 4'h0;
        data_A  = '0;
        data_Di = '0;
        unique case (state_q)
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(k_q);
            end
            S_WAIT_X: if (bus.x_valid) begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(wp_q);
                data_Di = bus.x_data;
            end
            S_MAC: begin
                data_EN = 1'b1;
                data_A  = word_addr(rd_idx);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_scheduler
//   Drives fir_mac_scheduler through directed and randomized runs with
//   behavioural tap/data RAMs. Expected outputs come from a direct FIR sum
//   over the sample list of each run (history zero before the first sample).
// ---------------------------------------------------------------------------
module tb_fir_mac_scheduler;
    localparam int NTAP = 11;
    localparam int AW   = 12;
    localparam int DW   = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic [31:0]   data_length = '0;
    logic          ap_done_clr = 1'b0;
    logic          ap_idle, ap_done;
    logic          tap_EN, data_EN;
    logic [3:0]    tap_WE, data_WE;
    logic [AW-1:0] tap_A, data_A;
    logic [DW-1:0] tap_Di, data_Di;
    logic [DW-1:0] tap_Do = '0;
    logic [DW-1:0] data_Do = '0;

    always #5 axis_clk = ~axis_clk;

    fir_mac_scheduler_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_mac_scheduler #(.NTAP(NTAP), .pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .ap_start(ap_start), .data_length(data_length), .ap_done_clr(ap_done_clr),
        .ap_idle(ap_idle), .ap_done(ap_done), .bus(bus),
        .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do),
        .data_EN(data_EN), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do)
    );

    // ---------------- RAM models (1-cycle read, byte write enables) ----------------
    logic [DW-1:0] tap_mem  [0:1023];
    logic [DW-1:0] data_mem [0:1023];

    always @(posedge axis_clk) begin
        if (tap_EN) begin
            for (int b = 0; b < 4; b++) if (tap_WE[b]) tap_mem[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
            tap_Do <= tap_mem[tap_A[11:2]];
        end
        if (data_EN) begin
            for (int b = 0; b < 4; b++) if (data_WE[b]) data_mem[data_A[11:2]][8*b +: 8] <= data_Di[8*b +: 8];
            data_Do <= data_mem[data_A[11:2]];
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] tap_ref [NTAP];
    logic [31:0] x_in [$];

    function automatic logic [31:0] model_y(input int i);
        logic [31:0] acc = '0;
        for (int k = 0; k < NTAP; k++)
            if (i - k >= 0) acc = acc + tap_ref[k] * x_in[i - k];
        return acc;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cfg_write(input int idx, input logic [31:0] v);
        int guard = 0;
        @(negedge axis_clk);
        bus.cfg_req = 1'b1; bus.cfg_we = 1'b1;
        bus.cfg_addr = AW'(4 * idx); bus.cfg_wdata = v;
        #1;
        while (!bus.cfg_gnt && guard < 100) begin @(negedge axis_clk); #1; guard++; end
        check("cfg_wr_gnt", 32'(bus.cfg_gnt), 32'd1);
        @(negedge axis_clk);
        bus.cfg_req = 1'b0; bus.cfg_we = 1'b0;
        tap_ref[idx] = v;
    endtask

    task automatic start_run(input int n);
        @(negedge axis_clk);
        data_length = 32'(n); ap_start = 1'b1;
        @(negedge axis_clk);
        ap_start = 1'b0;
        check("start_done_cleared", 32'(ap_done), 32'd0);
        check("start_busy", 32'(ap_idle), 32'd0);
    endtask

    // One run over x_in; stall>0 holds y_ready low that many cycles in OUT;
    // probe issues a tap read during the first sample's MAC phase.
    task automatic run_stream(input int n, input int stall, input bit probe);
        localparam int PA = 3;
        int guard, lat;
        logic [31:0] exp;
        start_run(n);
        for (int i = 0; i < n; i++) begin
            exp = model_y(i);
            repeat ($urandom_range(0, 2)) @(negedge axis_clk);
            bus.x_data = x_in[i]; bus.x_valid = 1'b1;
            guard = 0;
            while (!bus.x_ready && guard < 100) begin @(negedge axis_clk); guard++; end
            check("x_accept_wait", 32'(guard < 100), 32'd1);
            bus.y_ready = (stall == 0);
            @(negedge axis_clk);
            bus.x_valid = 1'b0;
            bus.x_data  = $urandom;
            if (probe && i == 0) begin
                bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = AW'(4 * PA);
            end
            lat = 1;
            while (!bus.y_valid && lat < 40) begin
                if (probe && i == 0) begin #1; check("cfg_gnt_blocked", 32'(bus.cfg_gnt), 32'd0); end
                @(negedge axis_clk); lat++;
            end
            check("y_latency", 32'(lat), 32'(NTAP + 2));
            check("y_data", bus.y_data, exp);
            check("y_last", 32'(bus.y_last), 32'(i == n - 1));
            for (int s = 0; s < stall; s++) begin
                @(negedge axis_clk);
                check("stall_y_valid", 32'(bus.y_valid), 32'd1);
                check("stall_y_data", bus.y_data, exp);
                check("stall_x_ready", 32'(bus.x_ready), 32'd0);
            end
            bus.y_ready = 1'b1;
            @(negedge axis_clk);
            bus.y_ready = 1'b0;
            check("y_valid_drop", 32'(bus.y_valid), 32'd0);
            if (probe && i == 0) begin
                #1;
                check("cfg_gnt_after", 32'(bus.cfg_gnt), 32'd1);
                @(negedge axis_clk);
                bus.cfg_req = 1'b0;
                check("cfg_rd_data", tap_Do, tap_ref[PA]);
            end
        end
        check("run_ap_done", 32'(ap_done), 32'd1);
        check("run_ap_idle", 32'(ap_idle), 32'd1);
    endtask

    task automatic run_empty();
        int guard = 0;
        bit saw_y = 1'b0;
        start_run(0);
        while (!ap_done && guard < 50) begin
            if (bus.y_valid) saw_y = 1'b1;
            @(negedge axis_clk); guard++;
        end
        check("empty_done_cycles", 32'(guard), 32'(NTAP));
        check("empty_no_y", 32'(saw_y), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.x_valid = 1'b0; bus.x_data = '0; bus.y_ready = 1'b0;
        bus.cfg_req = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        repeat (3) @(negedge axis_clk);
        check("rst_ap_idle", 32'(ap_idle), 32'd1);
        check("rst_ap_done", 32'(ap_done), 32'd0);
        check("rst_x_ready", 32'(bus.x_ready), 32'd0);
        check("rst_y_valid", 32'(bus.y_valid), 32'd0);
        check("rst_y_last", 32'(bus.y_last), 32'd0);
        check("rst_y_data", bus.y_data, 32'd0);
        check("rst_ram_en", {tap_EN, data_EN, tap_WE, data_WE}, 32'd0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check("post_rst_idle", 32'(ap_idle), 32'd1);

        // Moving sum: taps all 1, x = 1,2,3 -> y = 1,3,6.
        for (int i = 0; i < NTAP; i++) cfg_write(i, 32'd1);
        x_in = '{32'd1, 32'd2, 32'd3};
        run_stream(3, 0, 1'b0);

        @(negedge axis_clk);
        ap_done_clr = 1'b1;
        @(negedge axis_clk);
        ap_done_clr = 1'b0;
        check("done_clr", 32'(ap_done), 32'd0);
        check("done_clr_idle", 32'(ap_idle), 32'd1);

        // Impulse through taps k+1: y = 1..11 then zeros, wp wraps past NTAP.
        for (int i = 0; i < NTAP; i++) cfg_write(i, 32'(i + 1));
        x_in = {};
        x_in.push_back(32'd1);
        for (int i = 0; i < 16; i++) x_in.push_back(32'd0);
        run_stream(17, 0, 1'b0);

        // Backpressure: y_ready held low 5 cycles per output.
        x_in = {};
        for (int i = 0; i < 4; i++) x_in.push_back($urandom_range(0, 1000));
        run_stream(4, 5, 1'b0);

        // Tap read during MAC must wait for WAIT_X.
        x_in = '{32'd7, 32'd9};
        run_stream(2, 0, 1'b1);

        // Zero-length run, then a rerun that relies on the cleared history.
        run_empty();
        x_in = {};
        for (int i = 0; i < 5; i++) x_in.push_back($urandom);
        run_stream(5, 0, 1'b0);

        // Randomized runs with full-range taps and samples (32-bit wrap).
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 15);
            for (int i = 0; i < NTAP; i++) cfg_write(i, $urandom);
            x_in = {};
            for (int i = 0; i < n; i++) x_in.push_back($urandom);
            run_stream(n, (r % 2) * 3, 1'b0);
        end

        // Reset in the middle of a run aborts back to IDLE.
        start_run(3);
        repeat (4) @(negedge axis_clk);
        axis_rst_n = 1'b0;
        #1;
        check("midrun_rst_idle", 32'(ap_idle), 32'd1);
        check("midrun_rst_data_en", 32'(data_EN), 32'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check("midrun_rst_x_ready", 32'(bus.x_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
